// File: rtl/decoder_pkg.sv
// Shared defaults and types for the binary-to-one-hot decoder.
// Error tracking is built only when DECODER_ERR_TRACK_EN is defined.
package decoder_pkg;

  localparam int DEC_IN_W_DEF  = 2;
  localparam int DEC_OUT_W_DEF = 4;

  typedef logic [DEC_IN_W_DEF-1:0]  dec_sel_t;
  typedef logic [DEC_OUT_W_DEF-1:0] dec_onehot_t;

endpackage

// File: rtl/decoder_if.sv
// Select/decode bundle between the control unit and the decoder.
// err_sticky/oor are live only with DECODER_ERR_TRACK_EN.
interface decoder_if
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W_DEF,
  parameter int OUT_W = 1 << IN_W
);

  logic             en;
  logic [IN_W-1:0]  sel;
  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] dec_q;
  logic             oor;
  logic             err_sticky;

  modport master (
    output en,
    output sel,
    input  dec,
    input  dec_q,
    input  oor,
    input  err_sticky
  );

  modport slave (
    input  en,
    input  sel,
    output dec,
    output dec_q,
    output oor,
    output err_sticky
  );

endinterface

// File: rtl/decoder_err_tracker.sv
// Out-of-range detect and sticky error flag for narrow decoders.
// Instantiated by decoder only under DECODER_ERR_TRACK_EN.
module decoder_err_tracker
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W_DEF,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [IN_W-1:0] sel,
  output logic            oor,
  output logic            err_sticky
);

  // Zero-extended compare; never true when OUT_W covers every sel value.
  assign oor = en && (32'(sel) >= OUT_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky | oor;
    end
  end

endmodule

// File: rtl/decoder.sv
// Parameterised binary-to-one-hot decoder with registered copy.
// Optional DECODER_ERR_TRACK_EN adds oor and err_sticky tracking.
module decoder
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W_DEF,
  parameter int OUT_W = 1 << IN_W
) (
  input logic       clk,
  input logic       rst_n,
  decoder_if.slave  bus
);

  if (IN_W < 1 || OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_cfg
    $fatal(1, "decoder: illegal IN_W/OUT_W");
  end

  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] dec_q;
  logic             oor;
  logic             err_sticky;

  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign dec[i] = bus.en && (bus.sel == IN_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec;
    end
  end

`ifdef DECODER_ERR_TRACK_EN
  decoder_err_tracker #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_err (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .sel        (bus.sel),
    .oor        (oor),
    .err_sticky (err_sticky)
  );
`else
  assign oor        = 1'b0;
  assign err_sticky = 1'b0;
`endif

  assign bus.dec        = dec;
  assign bus.dec_q      = dec_q;
  assign bus.oor        = oor;
  assign bus.err_sticky = err_sticky;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: default 2->4 instance plus a narrow 2->3 one.
// Tracking expectations follow DECODER_ERR_TRACK_EN.
module tb_decoder;
  import decoder_pkg::*;

`ifdef DECODER_ERR_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_if #(.IN_W(2), .OUT_W(4)) ifa ();
  decoder_if #(.IN_W(2), .OUT_W(3)) ifb ();

  decoder #(.IN_W(2), .OUT_W(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  decoder #(.IN_W(2), .OUT_W(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic en, dec_sel_t sel);
    ifa.en  = en;
    ifa.sel = sel;
    ifb.en  = en;
    ifb.sel = sel;
  endtask

  typedef struct packed {
    logic        en;
    dec_sel_t    sel;
    dec_onehot_t dec4;
    logic [2:0]  dec3;
    logic        oor3;
  } vec_t;

  vec_t vecs[8];

  initial begin
    dec_onehot_t m4;
    logic [2:0]  m3;
    logic        sm;
    logic        e;
    dec_sel_t    s;

    vecs[0] = '{1'b1, 2'd0, 4'b0001, 3'b001, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'b0010, 3'b010, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 4'b0100, 3'b100, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 4'b1000, 3'b000, 1'b1};
    vecs[4] = '{1'b0, 2'd2, 4'b0000, 3'b000, 1'b0};
    vecs[5] = '{1'b0, 2'd3, 4'b0000, 3'b000, 1'b0};
    vecs[6] = '{1'b1, 2'd3, 4'b1000, 3'b000, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 4'b0000, 3'b000, 1'b0};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 2'd0);
    tick();
    tick();
    chk("rst_dec_q4", 32'(ifa.dec_q), 0);
    chk("rst_dec_q3", 32'(ifb.dec_q), 0);
    chk("rst_sticky", 32'(ifb.err_sticky), 0);
    rst_n = 1'b1;

    // Table sweep
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].sel);
      #1;
      chk($sformatf("dec4[%0d]", i), 32'(ifa.dec), 32'(vecs[i].dec4));
      chk($sformatf("dec3[%0d]", i), 32'(ifb.dec), 32'(vecs[i].dec3));
      chk($sformatf("oor3[%0d]", i), 32'(ifb.oor),
          32'(vecs[i].oor3 & TRK));
      chk($sformatf("oor4[%0d]", i), 32'(ifa.oor), 0);
      tick();
      chk($sformatf("dq4[%0d]", i), 32'(ifa.dec_q), 32'(vecs[i].dec4));
      chk($sformatf("dq3[%0d]", i), 32'(ifb.dec_q), 32'(vecs[i].dec3));
    end

    // Reset mid-stream with sel=3, en=1
    drive(1'b1, 2'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_dec_rst", 32'(ifa.dec), 32'h8);
    tick();
    chk("mid_dq_r1", 32'(ifa.dec_q), 0);
    chk("mid_dec_r1", 32'(ifa.dec), 32'h8);
    tick();
    chk("mid_dq_r2", 32'(ifa.dec_q), 0);
    chk("mid_st_r2", 32'(ifb.err_sticky), 0);
    rst_n = 1'b1;
    tick();
    chk("mid_dq_rel", 32'(ifa.dec_q), 32'h8);

    // Sticky error on the narrow instance
    drive(1'b0, 2'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("st_clear", 32'(ifb.err_sticky), 0);
    drive(1'b1, 2'd3);
    #1;
    chk("st_dec", 32'(ifb.dec), 0);
    chk("st_oor", 32'(ifb.oor), 32'(TRK));
    chk("st_pre", 32'(ifb.err_sticky), 0);
    tick();
    chk("st_set", 32'(ifb.err_sticky), 32'(TRK));
    drive(1'b1, 2'd0);
    #1;
    chk("st_oor0", 32'(ifb.oor), 0);
    tick();
    chk("st_hold", 32'(ifb.err_sticky), 32'(TRK));
    chk("st_dq", 32'(ifb.dec_q), 1);
    tick();
    chk("st_hold2", 32'(ifb.err_sticky), 32'(TRK));
    // Reset and oor on the same edge: reset wins
    drive(1'b1, 2'd3);
    rst_n = 1'b0;
    tick();
    chk("st_rst_win", 32'(ifb.err_sticky), 0);
    rst_n = 1'b1;
    drive(1'b0, 2'd3);
    #1;
    chk("st_en0_oor", 32'(ifb.oor), 0);
    tick();
    chk("st_en0", 32'(ifb.err_sticky), 0);

    // Random 2-state stream against a reference model
    sm = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      e = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      drive(e, s);
      m4 = e ? dec_onehot_t'(1) << s : '0;
      m3 = (e && s < 2'd3) ? 3'(1) << s : '0;
      #1;
      chk("rnd_dec4", 32'(ifa.dec), 32'(m4));
      chk("rnd_oh4", 32'($onehot0(ifa.dec)), 1);
      chk("rnd_dec3", 32'(ifb.dec), 32'(m3));
      chk("rnd_oor3", 32'(ifb.oor), 32'(TRK & e & (s == 2'd3)));
      sm = sm | (TRK & e & (s == 2'd3));
      tick();
      chk("rnd_dq4", 32'(ifa.dec_q), 32'(m4));
      chk("rnd_dq3", 32'(ifb.dec_q), 32'(m3));
      chk("rnd_st", 32'(ifb.err_sticky), 32'(sm));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
